// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - VIC/CPU request, memory command and status signals of mem_arbiter
interface mem_arbiter_if;
    logic        vic_req;
    logic [15:0] vic_addr;
    logic        vic_ack;
    logic [7:0]  vic_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [5:0]  cpu_bank;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        mem_cs;
    logic        mem_write;
    logic [5:0]  mem_bank;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_busy;
    logic        mem_data_ready;
    logic        o_owner;
    logic        o_timeout;

    modport slave (
        input  vic_req, vic_addr, cpu_req, cpu_we, cpu_addr, cpu_bank, cpu_wdata,
               mem_rdata, mem_busy, mem_data_ready,
        output vic_ack, vic_data, cpu_ack, cpu_rdata,
               mem_cs, mem_write, mem_bank, mem_addr, mem_wdata, o_owner, o_timeout
    );

    modport master (
        output vic_req, vic_addr, cpu_req, cpu_we, cpu_addr, cpu_bank, cpu_wdata,
               mem_rdata, mem_busy, mem_data_ready,
        input  vic_ack, vic_data, cpu_ack, cpu_rdata,
               mem_cs, mem_write, mem_bank, mem_addr, mem_wdata, o_owner, o_timeout
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (VIC/CPU) memory arbiter with bounded VIC runs and WAIT timeout
module mem_arbiter #(
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned MAX_VIC_RUN = 2,
    parameter logic [5:0]  VIC_BANK    = 6'd0
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned RCW = (MAX_VIC_RUN < 1) ? 1 : $clog2(MAX_VIC_RUN + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [RCW-1:0] RUN_MAX   = RCW'(MAX_VIC_RUN);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t         state;
    logic [RCW-1:0] vic_run;
    logic [WCW-1:0] wait_cnt;
    logic           busy_seen;
    logic           cpu_wins;
    logic           rd_done;
    logic           wr_done;

    // VIC has priority until it has used up its run while the CPU is waiting
    assign cpu_wins = bus.cpu_req && (!bus.vic_req || vic_run == RUN_MAX);
    assign rd_done  = !bus.mem_write && bus.mem_data_ready;
    assign wr_done  = bus.mem_write && busy_seen && !bus.mem_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            vic_run       <= '0;
            wait_cnt      <= '0;
            busy_seen     <= 1'b0;
            bus.vic_ack   <= 1'b0;
            bus.vic_data  <= 8'h00;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_rdata <= 8'h00;
            bus.mem_cs    <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_bank  <= 6'd0;
            bus.mem_addr  <= 16'h0000;
            bus.mem_wdata <= 8'h00;
            bus.o_owner   <= 1'b0;
            bus.o_timeout <= 1'b0;
        end else begin
            bus.vic_ack <= 1'b0;
            bus.cpu_ack <= 1'b0;
            bus.mem_cs  <= 1'b0;
            if (!bus.cpu_req) begin
                vic_run <= '0;
            end
            case (state)
                IDLE: begin
                    if (!bus.mem_busy && (bus.vic_req || bus.cpu_req)) begin
                        bus.mem_cs  <= 1'b1;
                        bus.o_owner <= cpu_wins;
                        state       <= ISSUE;
                        if (cpu_wins) begin
                            bus.mem_write <= bus.cpu_we;
                            bus.mem_addr  <= bus.cpu_addr;
                            bus.mem_bank  <= bus.cpu_bank;
                            bus.mem_wdata <= bus.cpu_wdata;
                            vic_run       <= '0;
                        end else begin
                            bus.mem_write <= 1'b0;
                            bus.mem_addr  <= bus.vic_addr;
                            bus.mem_bank  <= VIC_BANK;
                            bus.mem_wdata <= 8'h00;
                            if (bus.cpu_req && vic_run != RUN_MAX) begin
                                vic_run <= vic_run + RCW'(1);
                            end
                        end
                    end
                end
                ISSUE: begin
                    state     <= WAIT;
                    wait_cnt  <= '0;
                    busy_seen <= 1'b0;
                end
                WAIT: begin
                    if (bus.mem_busy) begin
                        busy_seen <= 1'b1;
                    end
                    if (rd_done || wr_done) begin
                        if (rd_done) begin
                            if (bus.o_owner) bus.cpu_rdata <= bus.mem_rdata;
                            else             bus.vic_data  <= bus.mem_rdata;
                        end
                        if (bus.o_owner) bus.cpu_ack <= 1'b1;
                        else             bus.vic_ack <= 1'b1;
                        state <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // abort: the owner still gets its ack, with all-ones data
                        if (bus.o_owner) begin
                            bus.cpu_rdata <= 8'hFF;
                            bus.cpu_ack   <= 1'b1;
                        end else begin
                            bus.vic_data  <= 8'hFF;
                            bus.vic_ack   <= 1'b1;
                        end
                        bus.o_timeout <= 1'b1;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int         TMO = 255;
    localparam logic [5:0] VB  = 6'd0;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(TMO), .MAX_VIC_RUN(2), .VIC_BANK(VB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory controller model: knobs set by the stimulus
    int         rd_delay  = 4;
    int         wr_busy   = 3;
    bit         mute      = 1'b0;
    bit         hold_busy = 1'b0;
    bit         stray     = 1'b0;
    bit         pend      = 1'b0;
    bit         pend_we   = 1'b0;
    int         pcnt      = 0;
    logic [21:0] pkey;
    logic [7:0] mem_arr [logic [21:0]];

    // reference state: what each requester's data register and the error flag must hold
    logic [7:0] exp_vic = 8'h00;
    logic [7:0] exp_cpu = 8'h00;
    logic       exp_tmo = 1'b0;

    int          seen;
    int          cpu_acks;
    bit          hit;
    logic        own_q [$];
    logic [15:0] r_addr;
    logic [15:0] last_addr = 16'h0;
    logic [5:0]  r_bank;
    logic [5:0]  last_bank = 6'd0;
    bit          r_who;
    bit          r_we;

    function automatic logic [7:0] mem_val(input logic [21:0] k);
        if (mem_arr.exists(k)) return mem_arr[k];
        return k[7:0] ^ k[15:8] ^ {2'b00, k[21:16]} ^ 8'h5A;
    endfunction

    always @(negedge clk) begin
        bus.mem_data_ready = 1'b0;
        bus.mem_busy       = hold_busy;
        if (!reset) begin
            pend = 1'b0;
        end else if (bus.mem_cs && !mute) begin
            pend    = 1'b1;
            pend_we = bus.mem_write;
            pcnt    = 0;
            pkey    = {bus.mem_bank, bus.mem_addr};
            if (bus.mem_write) mem_arr[pkey] = bus.mem_wdata;
        end else if (pend) begin
            pcnt++;
            if (pend_we) begin
                if (pcnt <= wr_busy) bus.mem_busy = 1'b1;
                else                 pend = 1'b0;
            end else if (pcnt == rd_delay) begin
                bus.mem_data_ready = 1'b1;
                bus.mem_rdata      = mem_val(pkey);
                pend               = 1'b0;
            end
        end
        if (stray) begin
            bus.mem_data_ready = 1'b1;
            bus.mem_rdata      = 8'hEE;
            stray              = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one request from VIC (who=0) or CPU (who=1); checks command, latency, ack pulse and data
    task automatic txn(input bit who, input bit we, input logic [15:0] addr, input logic [5:0] bank,
                       input logic [7:0] wd, input string tag);
        int         t_cs;
        int         lat;
        int         extra_cs;
        bit         got;
        logic [5:0] eb;
        logic [7:0] rd;
        eb  = who ? bank : VB;
        rd  = mem_val({eb, addr});
        lat = mute ? TMO + 1 : (who && we) ? wr_busy + 2 : rd_delay + 1;
        if (who) begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_bank = bank; bus.cpu_wdata = wd;
            bus.cpu_req = 1'b1;
        end else begin
            bus.vic_addr = addr;
            bus.vic_req  = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.mem_cs;
        end
        check({tag, " cs"}, got, 1);
        if (!got) begin
            bus.vic_req = 1'b0;
            bus.cpu_req = 1'b0;
            return;
        end
        t_cs = cyc;
        check({tag, " owner"}, bus.o_owner, who);
        check({tag, " write"}, bus.mem_write, who & we);
        check({tag, " addr"}, bus.mem_addr, addr);
        check({tag, " bank"}, bus.mem_bank, eb);
        if (who && we) check({tag, " wdata"}, bus.mem_wdata, wd);
        got = 1'b0;
        extra_cs = 0;
        for (int i = 0; i < TMO + 20 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_cs) extra_cs++;
            got = who ? bus.cpu_ack : bus.vic_ack;
        end
        if (who) bus.cpu_req = 1'b0;
        else     bus.vic_req = 1'b0;
        check({tag, " ack"}, got, 1);
        check({tag, " latency"}, cyc - t_cs, lat);
        check({tag, " cs pulses"}, extra_cs, 0);
        if (mute) begin
            if (who) exp_cpu = 8'hFF;
            else     exp_vic = 8'hFF;
            exp_tmo = 1'b1;
        end else if (!(who && we)) begin
            if (who) exp_cpu = rd;
            else     exp_vic = rd;
        end
        check({tag, " vic_data"}, bus.vic_data, exp_vic);
        check({tag, " cpu_rdata"}, bus.cpu_rdata, exp_cpu);
        check({tag, " o_timeout"}, bus.o_timeout, exp_tmo);
        @(negedge clk);
        check({tag, " ack width"}, {bus.vic_ack, bus.cpu_ack}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.vic_req = 1'b0; bus.vic_addr = 16'h0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0;
        bus.cpu_bank = 6'd0; bus.cpu_wdata = 8'h0;

        @(negedge clk);
        check("reset outputs",
              {bus.vic_ack, bus.cpu_ack, bus.mem_cs, bus.mem_write, bus.o_owner, bus.o_timeout,
               bus.mem_bank, bus.vic_data, bus.cpu_rdata}, 0);
        check("reset mem_addr", {bus.mem_addr, bus.mem_wdata}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        rd_delay = 4;
        txn(1'b1, 1'b0, 16'hC000, 6'd0, 8'h00, "cpu read C000");
        mem_arr[{6'd0, 16'hD020}] = 8'h00;
        wr_busy = 3;
        txn(1'b1, 1'b1, 16'hD020, 6'd0, 8'h05, "cpu write D020");
        mem_arr[{VB, 16'h0100}] = 8'h79;
        rd_delay = 1;
        txn(1'b0, 1'b0, 16'h0100, 6'd0, 8'h00, "vic read min latency");

        // busy memory at IDLE holds off the command
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h2222; bus.cpu_bank = 6'd1; bus.cpu_req = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.mem_cs) seen++;
        end
        check("cs while busy", seen, 0);
        hold_busy = 1'b0;
        rd_delay = 3;
        txn(1'b1, 1'b0, 16'h2222, 6'd1, 8'h00, "cpu read after busy");

        // both requesters held: VIC, VIC, CPU, ...
        rd_delay = 2;
        bus.vic_addr = 16'h0040;
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h8001; bus.cpu_bank = 6'd5;
        bus.vic_req = 1'b1; bus.cpu_req = 1'b1;
        cpu_acks = 0;
        for (int i = 0; i < 200 && own_q.size() < 6; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) cpu_acks++;
            if (bus.mem_cs) own_q.push_back(bus.o_owner);
        end
        bus.vic_req = 1'b0; bus.cpu_req = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.cpu_ack) cpu_acks++;
        end
        check("contention grants", own_q.size(), 6);
        for (int k = 0; k < own_q.size(); k++) check($sformatf("grant %0d owner", k), own_q[k], (k % 3) == 2);
        check("contention cpu acks", cpu_acks, 2);
        exp_vic = mem_val({VB, 16'h0040});
        exp_cpu = mem_val({6'd5, 16'h8001});
        check("contention vic_data", bus.vic_data, exp_vic);
        check("contention cpu_rdata", bus.cpu_rdata, exp_cpu);

        // silent memory: abort after TMO cycles in WAIT, flag stays set
        mute = 1'b1;
        txn(1'b0, 1'b0, 16'h0300, 6'd0, 8'h00, "vic timeout");
        mute = 1'b0;
        rd_delay = 2;
        txn(1'b0, 1'b0, 16'h0301, 6'd0, 8'h00, "vic after timeout");
        txn(1'b1, 1'b0, 16'h4444, 6'd2, 8'h00, "cpu after timeout");

        // reset in the middle of WAIT
        mute = 1'b1;
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234; bus.cpu_bank = 6'd3; bus.cpu_req = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            hit = bus.mem_cs;
        end
        check("reset test cs", hit, 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async reset outputs",
              {bus.vic_ack, bus.cpu_ack, bus.mem_cs, bus.mem_write, bus.o_owner, bus.o_timeout,
               bus.mem_bank, bus.vic_data, bus.cpu_rdata}, 0);
        check("async reset mem_addr", {bus.mem_addr, bus.mem_wdata}, 0);
        bus.cpu_req = 1'b0;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.vic_ack || bus.mem_cs) seen++;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.vic_ack || bus.mem_cs) seen++;
        end
        check("no ack after reset", seen, 0);
        mute = 1'b0;
        exp_vic = 8'h00; exp_cpu = 8'h00; exp_tmo = 1'b0;
        rd_delay = 4;
        txn(1'b1, 1'b0, 16'hC000, 6'd0, 8'h00, "cpu after reset");

        // randomized single transactions with stray ready pulses while idle
        for (int n = 0; n < 30; n++) begin
            rd_delay = 1 + $urandom_range(5);
            wr_busy  = 1 + $urandom_range(4);
            r_who    = 1'($urandom_range(1));
            r_we     = r_who & 1'($urandom_range(1));
            r_addr   = 16'($urandom);
            r_bank   = 6'($urandom);
            if ($urandom_range(2) == 0) begin
                r_addr = last_addr;
                r_bank = last_bank;
            end
            if ($urandom_range(3) == 0) begin
                stray = 1'b1;
                repeat (3) @(negedge clk);
            end
            txn(r_who, r_we, r_addr, r_bank, 8'($urandom), $sformatf("rand %0d", n));
            last_addr = r_addr;
            last_bank = r_who ? r_bank : VB;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
